// File: rtl/codec_init_sequencer.sv
// Walks INIT_TABLE entry by entry and offers each address/data word to an I2C master.
// Define CODEC_INIT_RETRY_EN to re-send NACKed entries up to MAX_RETRIES times.
module codec_init_sequencer #(
  parameter int ADDR_W        = 7,
  parameter int DATA_W        = 9,
  parameter int NUM_REGS      = 10,
  parameter logic [NUM_REGS*(ADDR_W+DATA_W)-1:0] INIT_TABLE = '0,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                          i2c_clk,
  input  logic                          reset,
  input  logic                          start,
  output logic [ADDR_W+DATA_W-1:0]      reg_and_data,
  output logic                          valid,
  input  logic                          ready,
  input  logic                          xfer_done,
  input  logic                          ack_ok,
  output logic [$clog2(NUM_REGS+1)-1:0] index,
  output logic                          done,
  output logic                          error,
  output logic [2:0]                    state_dbg
);
  localparam int WORD_W = ADDR_W + DATA_W;
  localparam int IDX_W  = $clog2(NUM_REGS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [7:0] SETTLE_LAST = (SETTLE_CYCLES > 1) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SEND   = 3'd2,
    WAIT   = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  state_t     state, state_n;
  logic [7:0] settle_cnt;
  logic       settle_end;
  logic       last_entry;
  logic       restart;
  logic       can_retry;

  assign settle_end = (settle_cnt == SETTLE_LAST);
  assign last_entry = (index == LAST_IDX);
  assign restart    = ((state == DONE) || (state == ERROR)) && start;

`ifdef CODEC_INIT_RETRY_EN
  logic [3:0] retry_cnt;

  assign can_retry = (retry_cnt < 4'(MAX_RETRIES));

  always_ff @(posedge i2c_clk or posedge reset) begin
    if (reset) begin
      retry_cnt <= '0;
    end else if (restart) begin
      retry_cnt <= '0;
    end else if ((state == WAIT) && xfer_done) begin
      if (ack_ok) begin
        retry_cnt <= '0;
      end else if (can_retry) begin
        retry_cnt <= retry_cnt + 4'd1;
      end
    end
  end
`else
  assign can_retry = 1'b0;
`endif

  always_ff @(posedge i2c_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Handshake: the master takes reg_and_data on the rising edge where valid && ready are
  // both high; until then valid stays asserted and the word does not change.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = LOAD;
      LOAD:    state_n = SEND;
      SEND:    if (ready) state_n = WAIT;
      WAIT: begin
        if (xfer_done) begin
          if (ack_ok)         state_n = SETTLE;
          else if (can_retry) state_n = LOAD;
          else                state_n = ERROR;
        end
      end
      SETTLE:  if (settle_end) state_n = last_entry ? DONE : LOAD;
      DONE:    if (start) state_n = LOAD;
      ERROR:   if (start) state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i2c_clk or posedge reset) begin
    if (reset) begin
      index        <= '0;
      settle_cnt   <= '0;
      reg_and_data <= '0;
    end else begin
      if (restart) begin
        index <= '0;
      end else if ((state == SETTLE) && settle_end && !last_entry) begin
        index <= index + IDX_W'(1);
      end

      // A zero-length settle still passes through SETTLE for one cycle.
      if ((state == SETTLE) && !settle_end) begin
        settle_cnt <= settle_cnt + 8'd1;
      end else begin
        settle_cnt <= '0;
      end

      if (state == LOAD) begin
        reg_and_data <= INIT_TABLE[int'(index)*WORD_W +: WORD_W];
      end
    end
  end

  assign valid     = (state == SEND);
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign state_dbg = state;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: scenario table, randomized sessions against a transaction-level
// model of the init sequence, and a reset-abort sequence.
module tb_codec_init_sequencer;
  localparam int NR  = 10;
  localparam int AW  = 7;
  localparam int DW  = 9;
  localparam int WW  = AW + DW;
  localparam int MAX_RETRIES = 3;
`ifdef CODEC_INIT_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  function automatic logic [NR*WW-1:0] make_table();
    logic [NR*WW-1:0] t;
    t = '0;
    for (int i = 0; i < NR; i++) begin
      t[i*WW +: WW] = {7'(7'h10 + i*3), 9'(9'h0A5 ^ (i*41))};
    end
    return t;
  endfunction

  localparam logic [NR*WW-1:0] TABLE = make_table();

  // clock / reset
  logic          i2c_clk;
  logic          reset;
  logic          start;
  logic [WW-1:0] reg_and_data;
  logic          valid;
  logic          ready;
  logic          xfer_done;
  logic          ack_ok;
  logic [3:0]    index;
  logic          done;
  logic          error;
  logic [2:0]    state_dbg;

  initial i2c_clk = 1'b0;
  always #5 i2c_clk = ~i2c_clk;

  codec_init_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .INIT_TABLE(TABLE),
    .SETTLE_CYCLES(4), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .i2c_clk(i2c_clk), .reset(reset), .start(start),
    .reg_and_data(reg_and_data), .valid(valid), .ready(ready),
    .xfer_done(xfer_done), .ack_ok(ack_ok), .index(index),
    .done(done), .error(error), .state_dbg(state_dbg)
  );

  typedef struct {
    int stall_entry;
    int stall;
    int nack_entry;
    int nack_times;
    bit exp_done;
    bit exp_error;
    int exp_index;
    int exp_hs;
  } scen_t;

  scen_t         scen[5];
  logic [WW-1:0] tbl[NR];
  logic [WW-1:0] exp_q[$];
  int            checks;
  int            failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver + model: plays the I2C master for one pass through the table
  task automatic run_session(input scen_t c, input bit rnd, input int abort_entry, input bit use_start);
    int m_entry, m_retry, done_cd, err_cd, wait_cd, stall_left, hs, cyc, tail;
    bit m_done, m_err, waiting, in_send, abort_now, ack;
    logic [WW-1:0] held_word, exp_w;
    m_entry = 0; m_retry = 0; done_cd = 0; err_cd = 0; wait_cd = 0; stall_left = 0;
    hs = 0; cyc = 0; tail = 0;
    m_done = 0; m_err = 0; waiting = 0; in_send = 0; abort_now = 0; ack = 0;
    held_word = '0;
    exp_q.delete();
    exp_q.push_back(tbl[0]);
    if (use_start) begin
      @(negedge i2c_clk);
      start = 1'b1;
    end
    while (tail < 4) begin
      @(negedge i2c_clk);
      start = 1'b0; xfer_done = 1'b0; ack_ok = 1'b0;
      if (abort_now) return;
      cyc++;
      if (cyc > 3000) begin
        checks++; failures++;
        $display("FAIL session_budget actual=%0d cycles required=done or error", cyc);
        return;
      end
      if (done_cd > 0) begin done_cd--; if (done_cd == 0) m_done = 1; end
      if (err_cd > 0)  begin err_cd--;  if (err_cd == 0)  m_err = 1;  end
      check("done", done, m_done);
      check("error", error, m_err);
      if (m_done || m_err) begin
        tail++;
        check("valid_after_end", valid, 0);
        check("index_final", index, m_done ? NR-1 : m_entry);
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        continue;
      end
      if (waiting) check("valid_in_wait", valid, 0);
      if (in_send) begin
        check("valid_hold", valid, 1);
        check("word_hold", reg_and_data, held_word);
      end else if (valid && !waiting) begin
        in_send = 1; held_word = reg_and_data;
        stall_left = rnd ? int'($urandom_range(0, 3)) : ((m_entry == c.stall_entry) ? c.stall : 0);
      end
      if (in_send) begin
        if (stall_left > 0) begin
          ready = 1'b0; stall_left--;
        end else begin
          ready = 1'b1; in_send = 0; hs++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_handshake actual=%0h required=none", reg_and_data);
          end else begin
            exp_w = exp_q.pop_front();
            check("word", reg_and_data, exp_w);
          end
          check("index", index, m_entry);
          waiting = 1;
          wait_cd = 1 + (rnd ? int'($urandom_range(0, 3)) : 1);
          if (m_entry == abort_entry) abort_now = 1;
        end
      end else begin
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (waiting) begin
          wait_cd--;
          if (wait_cd == 0) begin
            waiting = 0; xfer_done = 1'b1;
            ack = rnd ? ($urandom_range(0, 5) != 0)
                      : !((m_entry == c.nack_entry) && (m_retry < c.nack_times));
            ack_ok = ack;
            if (ack) begin
              m_retry = 0;
              if (m_entry == NR-1) done_cd = 5;
              else begin m_entry++; exp_q.push_back(tbl[m_entry]); end
            end else if (RETRY_EN && (m_retry < MAX_RETRIES)) begin
              m_retry++; exp_q.push_back(tbl[m_entry]);
            end else begin
              err_cd = 1;
            end
          end
        end else if (rnd) begin
          if ($urandom_range(0, 7) == 0) begin xfer_done = 1'b1; ack_ok = 1'($urandom_range(0, 1)); end
          if ($urandom_range(0, 9) == 0) start = 1'b1;
        end
      end
    end
    check("queue_empty", exp_q.size(), 0);
    if (!rnd) begin
      check("scen_done", done, c.exp_done);
      check("scen_error", error, c.exp_error);
      check("scen_index", index, c.exp_index);
      check("scen_handshakes", hs, c.exp_hs);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; ready = 1'b0; xfer_done = 1'b0; ack_ok = 1'b0;
    for (int i = 0; i < NR; i++) tbl[i] = TABLE[i*WW +: WW];
    scen[0] = '{-1, 0, -1, 0, 1'b1, 1'b0, 9, 10};
    scen[1] = '{ 3, 7, -1, 0, 1'b1, 1'b0, 9, 10};
`ifdef CODEC_INIT_RETRY_EN
    scen[2] = '{-1, 0,  2,  2, 1'b1, 1'b0, 9, 12};
    scen[3] = '{-1, 0,  4, 99, 1'b0, 1'b1, 4, 8};
    scen[4] = '{ 1, 2,  0,  3, 1'b1, 1'b0, 9, 13};
`else
    scen[2] = '{-1, 0,  0,  1, 1'b0, 1'b1, 0, 1};
    scen[3] = '{-1, 0,  5,  1, 1'b0, 1'b1, 5, 6};
    scen[4] = '{ 6, 3, -1,  0, 1'b1, 1'b0, 9, 10};
`endif
    #3;
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_index", index, 0);
    check("rst_word", reg_and_data, 0);
    @(negedge i2c_clk);
    reset = 1'b0;

    run_session(scen[0], 1'b0, -1, 1'b0);
    for (int i = 1; i < 5; i++) run_session(scen[i], 1'b0, -1, 1'b1);
    for (int i = 0; i < 8; i++) run_session(scen[0], 1'b1, -1, 1'b1);

    run_session(scen[0], 1'b0, 6, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("abort_valid", valid, 0);
    check("abort_done", done, 0);
    check("abort_error", error, 0);
    check("abort_index", index, 0);
    check("abort_word", reg_and_data, 0);
    @(negedge i2c_clk);
    check("abort_hold_valid", valid, 0);
    @(negedge i2c_clk);
    reset = 1'b0;
    run_session(scen[0], 1'b0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/codec_init_sequencer.md
CODEC_INIT_SEQUENCER -- requirements
Module: codec_init_sequencer

Interface
REQ-001 Parameter ADDR_W, default 7, register address width.
REQ-002 Parameter DATA_W, default 9, register data width.
REQ-003 Parameter NUM_REGS, default 10, table entries, range 1..64.
REQ-004 Parameter INIT_TABLE, default all-zero, packed array of NUM_REGS words of ADDR_W+DATA_W bits; entry 0 occupies the LSBs.
REQ-005 Parameter SETTLE_CYCLES, default 4, idle cycles after each acknowledged write, range 0..255.
REQ-006 Parameter MAX_RETRIES, default 3, re-sends allowed per entry after a NACK, range 0..15.
REQ-007 i2c_clk  in  1  sole clock; all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse that re-runs the sequence from entry 0.
REQ-010 reg_and_data  out  ADDR_W+DATA_W  current word; address in the MSBs, data in the LSBs.
REQ-011 valid  out  1  word offered to the I2C master.
REQ-012 ready  in  1  I2C master accepts the word when valid&ready.
REQ-013 xfer_done  in  1  one-cycle pulse when the I2C transfer completes.
REQ-014 ack_ok  in  1  sampled only with xfer_done: 1 = ACK, 0 = NACK.
REQ-015 index  out  clog2(NUM_REGS+1)  entry currently being processed.
REQ-016 done  out  1  high while in DONE.
REQ-017 error  out  1  high while in ERROR.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, LOAD, SEND, WAIT, SETTLE, DONE, ERROR.
REQ-019 IDLE->LOAD unconditionally on the first clock after reset deasserts, so the sequence starts automatically.
REQ-020 LOAD latches INIT_TABLE[index] into reg_and_data and moves to SEND after 1 cycle.
REQ-021 SEND asserts valid and holds reg_and_data stable until the cycle in which valid&ready is sampled high; the FSM then moves to WAIT with valid low on the next cycle.
REQ-022 WAIT ignores ready; on xfer_done&ack_ok it moves to SETTLE and clears the retry count.
REQ-023 SETTLE counts SETTLE_CYCLES cycles, where 0 means 0 extra cycles; it then increments index and goes to LOAD, or goes to DONE if index==NUM_REGS-1.
REQ-024 On xfer_done&!ack_ok, behaviour is defined by REQ-032/REQ-033.
REQ-025 In DONE or ERROR, start SHALL reset index to 0 and the retry count to 0, then go to LOAD.
REQ-026 start SHALL be ignored in LOAD, SEND, WAIT and SETTLE.
REQ-027 xfer_done in any state other than WAIT SHALL be ignored.
REQ-028 Exactly one valid&ready acceptance SHALL occur per transfer attempt.
REQ-029 Index SHALL never exceed NUM_REGS-1 and SHALL stay at its final value while in DONE or ERROR.

Reset
REQ-030 While reset is high: state=IDLE, index=0, retry count=0, settle count=0, reg_and_data=0, valid=0, done=0, error=0.
REQ-031 Reset asserted mid-transfer SHALL abort immediately with no further valid; the sequence restarts from entry 0 after release.

Configuration
REQ-032 With CODEC_INIT_RETRY_EN defined: on a NACK with retry count < MAX_RETRIES, the block increments the retry count and goes to LOAD for the same index; on a NACK with retry count == MAX_RETRIES, it goes to ERROR.
REQ-033 Without CODEC_INIT_RETRY_EN: any NACK goes directly to ERROR, MAX_RETRIES is unused, and no retry counter is synthesised.

Verification
REQ-034 NUM_REGS=10, SETTLE_CYCLES=4, ready always 1, ACK every transfer -> 10 handshakes in table order; done rises 5 cycles after the 10th xfer_done; error stays 0.
REQ-035 ready held low for 7 cycles during SEND -> valid and reg_and_data stay stable for all 7 cycles; exactly one acceptance occurs.
REQ-036 RETRY_EN, MAX_RETRIES=3, entry 2 NACKed twice then ACKed -> entry 2 is sent 3 times, the sequence completes, and done=1.
REQ-037 RETRY_EN, entry 4 always NACKed -> 4 attempts on entry 4, then error=1 with index=4; a start pulse afterwards restarts from index 0.
REQ-038 Macro undefined, NACK on entry 0 -> error=1 on the cycle after xfer_done; no second valid is issued.
REQ-039 Reset pulsed during WAIT of entry 6 -> all outputs return to 0 asynchronously; after release, the first accepted word is INIT_TABLE[0].
